// File: rtl/hazard_stall_controller.sv
// ID-stage hazard controller: load-use stalls, branch/jump flushes and, with MULT_STALL_EN
// defined, stalling for MultCycles-cycle MULT/DIV occupancy of EX.
module hazard_stall_controller #(
   parameter int unsigned MultCycles = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        id_uses_rt_i,
   input  logic        ex_mem_read_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        id_branch_taken_i,
   input  logic        id_jump_i,
   input  logic        id_is_mult_i,
   output logic        pc_enable_o,
   output logic        if_id_enable_o,
   output logic        if_id_flush_o,
   output logic        id_ex_bubble_o,
   output logic        busy_o,
   output logic [15:0] stall_count_o
);

   if (MultCycles < 1) begin : g_param_check
      $error("MultCycles must be at least 1");
   end

   localparam logic [15:0] StallMax = 16'hFFFF;

   logic        lu;
   logic        redirect;
   logic        pc_en;
   logic        ifid_en;
   logic        flush;
   logic        bubble;
   logic        busy;
   logic [15:0] stall_count_q, stall_count_d;

   // Register 0 is hardwired, so a load targeting it can never create a dependency.
   assign lu = ex_mem_read_i & (ex_rt_i != 5'd0) &
               ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
   assign redirect = id_branch_taken_i | id_jump_i;

`ifdef MULT_STALL_EN
   localparam int unsigned CntW = $clog2(MultCycles + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(MultCycles - 1);

   typedef enum logic [0:0] {StIdle, StMultBusy} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      flush   = 1'b0;
      bubble  = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         StMultBusy: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
            busy    = 1'b1;
            // Leaving on cnt<=1 also recovers from any corrupted count.
            if (cnt_q <= CntW'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            if (lu) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               bubble  = 1'b1;
            end else begin
               flush = redirect;
               // A redirect squashes the multiply's entry into the busy period.
               if (id_is_mult_i && !redirect && (MultCycles > 1)) begin
                  state_d = StMultBusy;
                  cnt_d   = CntLoad;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
      end
   end
`else
   logic unused_mult;
   assign unused_mult = id_is_mult_i;

   always_comb begin
      pc_en   = !lu;
      ifid_en = !lu;
      bubble  = lu;
      flush   = !lu & redirect;
      busy    = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end
`endif

   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_en && (stall_count_q != StallMax)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   // While reset is held the pipeline free-runs so the front end can flush itself.
   always_comb begin
      if (!rst_ni) begin
         pc_enable_o    = 1'b1;
         if_id_enable_o = 1'b1;
         if_id_flush_o  = 1'b0;
         id_ex_bubble_o = 1'b0;
         busy_o         = 1'b0;
      end else begin
         pc_enable_o    = pc_en;
         if_id_enable_o = ifid_en;
         if_id_flush_o  = flush;
         id_ex_bubble_o = bubble;
         busy_o         = busy;
      end
   end

   assign stall_count_o = stall_count_q;

`ifndef SYNTHESIS
   flush_advances: assert property (@(posedge clk_i) disable iff (!rst_ni)
      if_id_flush_o |-> (pc_enable_o && if_id_enable_o));
   busy_stalls: assert property (@(posedge clk_i) disable iff (!rst_ni)
      busy_o |-> (!pc_enable_o && id_ex_bubble_o));
   stall_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (pc_enable_o == if_id_enable_o) && (pc_enable_o == !id_ex_bubble_o));
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed plan items, random traffic, saturation.
module tb_hazard_stall_controller;

   localparam int unsigned MC = 4;
`ifdef MULT_STALL_EN
   localparam bit MultEn = 1'b1;
`else
   localparam bit MultEn = 1'b0;
`endif

   typedef struct packed {
      logic        pc;
      logic        ifid;
      logic        flush;
      logic        bubble;
      logic        busy;
      logic [15:0] sc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic        id_branch_taken = 1'b0, id_jump = 1'b0, id_is_mult = 1'b0;
   logic        pc_enable, if_id_enable, if_id_flush, id_ex_bubble, busy;
   logic [15:0] stall_count;

   hazard_stall_controller #(.MultCycles(MC)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .id_rs_i           (id_rs),
      .id_rt_i           (id_rt),
      .id_uses_rt_i      (id_uses_rt),
      .ex_mem_read_i     (ex_mem_read),
      .ex_rt_i           (ex_rt),
      .id_branch_taken_i (id_branch_taken),
      .id_jump_i         (id_jump),
      .id_is_mult_i      (id_is_mult),
      .pc_enable_o       (pc_enable),
      .if_id_enable_o    (if_id_enable),
      .if_id_flush_o     (if_id_flush),
      .id_ex_bubble_o    (id_ex_bubble),
      .busy_o            (busy),
      .stall_count_o     (stall_count)
   );

   always #5 clk = ~clk;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   // Reference state: stall cycles still owed to a multiply, and the total stalled cycles.
   int    owed = 0;
   int    stalls = 0;

   task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic mr, input logic [4:0] xrt, input logic br,
                       input logic j, input logic mul);
      obs_t e;
      bit   hazard;
      @(negedge clk);
      rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr; ex_rt = xrt;
      id_branch_taken = br; id_jump = j; id_is_mult = mul;
      #1;
      if (!r) begin
         owed   = 0;
         stalls = 0;
         e      = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, bubble: 1'b0, busy: 1'b0, sc: 16'd0};
      end else begin
         e.sc = 16'(stalls);
         hazard = mr && (xrt != 0) && ((xrt == rs) || (ur && (xrt == rt)));
         if (owed > 0) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.flush = 1'b0; e.bubble = 1'b1; e.busy = 1'b1;
            owed--;
         end else if (hazard) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.flush = 1'b0; e.bubble = 1'b1; e.busy = 1'b0;
         end else begin
            e.pc = 1'b1; e.ifid = 1'b1; e.flush = br | j; e.bubble = 1'b0; e.busy = 1'b0;
            if (MultEn && mul && !(br || j)) owed = int'(MC) - 1;
         end
         if (!e.pc && stalls < 65535) stalls++;
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
   endtask

   // Monitor: compare the presented outputs against the oldest queued expectation each cycle.
   initial begin : monitor
      obs_t  got, want;
      string tag;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = '{pc: pc_enable, ifid: if_id_enable, flush: if_id_flush, bubble: id_ex_bubble,
                     busy: busy, sc: stall_count};
            n_checks++;
            if (got === want) n_pass++;
            else $display("FAIL %s: got pc=%b ifid=%b flush=%b bub=%b busy=%b sc=%0d, want pc=%b ifid=%b flush=%b bub=%b busy=%b sc=%0d",
                          tag, got.pc, got.ifid, got.flush, got.bubble, got.busy, got.sc,
                          want.pc, want.ifid, want.flush, want.bubble, want.busy, want.sc);
         end
      end
   end

   initial begin : stimulus
      step("reset", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      step("reset_hold", 0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0);
      idle("post_reset", 2);

      step("lu_hit", 1, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0);
      idle("lu_after", 2);
      step("lu_r0", 1, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0, 0);
      step("rt_unused", 1, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0, 0);
      step("rt_used", 1, 5'd4, 5'd9, 1, 1, 5'd9, 0, 0, 0);
      idle("rt_after", 1);

      step("branch", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
      step("jump", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
      step("branch_lu", 1, 5'd8, 5'd2, 0, 1, 5'd8, 1, 0, 0);
      step("branch_defer", 1, 5'd8, 5'd2, 0, 0, 5'd8, 1, 0, 0);
      idle("flush_after", 1);

      step("mult", 1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1);
      idle("mult_busy", 4);
      step("mult_branch", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 1);
      idle("mult_branch_after", 1);
      step("mult_held", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1);
      step("mult_held_br", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
      step("mult_held_br2", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
      step("mult_held_br3", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
      step("mult_held_br4", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);

      step("mult_rst", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1);
      idle("mult_rst_busy", 2);
      step("mult_rst_assert", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
      idle("mult_rst_release", 2);

      for (int i = 0; i < 3000; i++) begin
         step("random", ($urandom_range(0, 199) != 0), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 6) == 0));
      end

      step("sat_reset", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      for (int i = 0; i < 65540; i++) step("saturate", 1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0);
      step("sat_hold", 1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0);
      idle("sat_release", 2);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
